burst_deserializer: RTL and testbench

- Receive-side counterpart of the framed burst-clock generator. Takes one serial channel: a frame enable, a gated burst clock and serial data.
- Oversamples all three inputs on a single fast system clock and reassembles each burst into one parallel word.
- Presents the word on a valid/ready interface to downstream framing logic.
- Flags malformed bursts and overflow. One instance per channel (clk1..clk4 equivalents).

---
 rtl/burst_pkg.sv | 17 +
 rtl/sync_edge_det.sv | 40 ++++
 rtl/burst_deserializer.sv | 160 ++++++++++++++++
 tb/tb_burst_deserializer.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/burst_pkg.sv
// Shared types and sizing helpers for the burst deserializer slice.
package burst_pkg;

  localparam int NUM_BITS_DEF = 32;

  // Counter must be able to hold NUM_BITS itself, not just NUM_BITS-1.
  function automatic int cnt_width(input int num_bits);
    return $clog2(num_bits + 1);
  endfunction

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    CHECK
  } state_e;

endpackage

// File: rtl/sync_edge_det.sv
// Two-flop synchronizer for an asynchronous level, followed by registered
// rise/fall detection (three clk from pin change to a detect pulse).
module sync_edge_det #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic async_i,
  output logic rise_o,
  output logic fall_o
);

  logic meta_q;
  logic sync_q;
  logic prev_q;
  logic rise_q;
  logic fall_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbour; blocking here would collapse the chain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
      prev_q <= RST_VAL;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      meta_q <= async_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
      rise_q <= sync_q & ~prev_q;
      fall_q <= ~sync_q & prev_q;
    end
  end

  assign rise_o = rise_q;
  assign fall_o = fall_q;

endmodule

// File: rtl/burst_deserializer.sv
// Oversampling receiver for one framed burst channel: reassembles each
// ser_en-framed burst of ser_clk bits into a word on a valid/ready port.
module burst_deserializer
  import burst_pkg::*;
#(
  parameter int NUM_BITS  = NUM_BITS_DEF,
  parameter bit MSB_FIRST = 1'b1,
  parameter int CNT_W     = cnt_width(NUM_BITS)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                ser_en,
  input  logic                ser_clk,
  input  logic                ser_data,
  output logic [NUM_BITS-1:0] word_data,
  output logic                word_valid,
  input  logic                word_ready,
  output logic                err_len,
  output logic                overflow,
  input  logic                clr_err
);

  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(NUM_BITS);

  logic en_rise;
  logic en_fall;
  logic sclk_rise;
  logic sclk_fall_unused;
  logic en_rise_unused;

  // ser_en resets its synchronizer to "high" so a burst already running when
  // reset releases cannot produce an en_rise; a real low must be seen first.
  sync_edge_det #(.RST_VAL(1'b1)) u_en_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .async_i(ser_en),
    .rise_o (en_rise),
    .fall_o (en_fall)
  );

  sync_edge_det #(.RST_VAL(1'b0)) u_sclk_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .async_i(ser_clk),
    .rise_o (sclk_rise),
    .fall_o (sclk_fall_unused)
  );

  assign en_rise_unused = sclk_fall_unused;

  logic [2:0]          data_dly_q;
  logic                data_bit;
  state_e              state_q,      state_d;
  logic [CNT_W-1:0]    cnt_q,        cnt_d;
  logic [NUM_BITS-1:0] shift_q,      shift_d;
  logic                overrun_q,    overrun_d;
  logic [NUM_BITS-1:0] word_data_q,  word_data_d;
  logic                word_valid_q, word_valid_d;
  logic                err_len_q,    err_len_d;
  logic                overflow_q,   overflow_d;

  // Three stages keep the data bit aligned with the registered sclk_rise.
  assign data_bit = data_dly_q[2];

  // NOTE: every register here, including the word holding register, has a
  // reset value because word_data must read 0 out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_dly_q   <= '0;
      state_q      <= IDLE;
      cnt_q        <= '0;
      shift_q      <= '0;
      overrun_q    <= 1'b0;
      word_data_q  <= '0;
      word_valid_q <= 1'b0;
      err_len_q    <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      data_dly_q   <= {data_dly_q[1:0], ser_data};
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      shift_q      <= shift_d;
      overrun_q    <= overrun_d;
      word_data_q  <= word_data_d;
      word_valid_q <= word_valid_d;
      err_len_q    <= err_len_d;
      overflow_q   <= overflow_d;
    end
  end

  // NOTE: every signal written below gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    shift_d      = shift_q;
    overrun_d    = overrun_q;
    word_data_d  = word_data_q;
    word_valid_d = word_valid_q;
    err_len_d    = 1'b0;
    overflow_d   = overflow_q;

    if (word_valid_q && word_ready) begin
      word_valid_d = 1'b0;
    end
    if (clr_err) begin
      overflow_d = 1'b0;
    end

    unique case (state_q)
      IDLE: begin
        // Stray sclk_rise here (e.g. a trailing pulse) is deliberately ignored.
        if (en_rise) begin
          cnt_d     = '0;
          shift_d   = '0;
          overrun_d = 1'b0;
          state_d   = SHIFT;
        end
      end

      SHIFT: begin
        if (sclk_rise) begin
          if (cnt_q < FULL_CNT) begin
            shift_d = MSB_FIRST ? {shift_q[NUM_BITS-2:0], data_bit}
                                : {data_bit, shift_q[NUM_BITS-1:1]};
            cnt_d   = cnt_q + 1'b1;
          end else begin
            overrun_d = 1'b1;
          end
        end
        if (en_fall) begin
          state_d = CHECK;
        end
      end

      CHECK: begin
        state_d = IDLE;
        if (cnt_q == FULL_CNT && !overrun_q) begin
          // A same-cycle handshake frees the holding register for the new word.
          if (!word_valid_q || word_ready) begin
            word_data_d  = shift_q;
            word_valid_d = 1'b1;
          end else begin
            overflow_d = 1'b1;
          end
        end else begin
          err_len_d = 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign word_data  = word_data_q;
  assign word_valid = word_valid_q;
  assign err_len    = err_len_q;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_burst_deserializer.sv
// Self-checking bench: table of framed bursts, hand-timed corner sequences
// and randomized bursts checked against a transaction-level model.
module tb_burst_deserializer;

  logic        clk;
  logic        rst_n;
  logic        ser_en;
  logic        ser_clk;
  logic        ser_data;
  logic        word_ready;
  logic        clr_err;
  logic [31:0] word_data;
  logic        word_valid;
  logic        err_len;
  logic        overflow;
  logic [31:0] lsb_data;
  logic        lsb_valid;
  logic        lsb_err_len;
  logic        lsb_overflow;

  int total = 0;
  int bad   = 0;
  int err_cnt = 0;
  bit rnd_on = 1'b0;
  logic [31:0] got_q[$];
  logic [31:0] got_lsb_q[$];
  logic [31:0] exp_q[$];
  logic [31:0] exp_lsb_q[$];

  burst_deserializer #(.NUM_BITS(32), .MSB_FIRST(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .ser_en(ser_en), .ser_clk(ser_clk), .ser_data(ser_data),
    .word_data(word_data), .word_valid(word_valid), .word_ready(word_ready),
    .err_len(err_len), .overflow(overflow), .clr_err(clr_err)
  );

  burst_deserializer #(.NUM_BITS(32), .MSB_FIRST(1'b0)) dut_lsb (
    .clk(clk), .rst_n(rst_n), .ser_en(ser_en), .ser_clk(ser_clk), .ser_data(ser_data),
    .word_data(lsb_data), .word_valid(lsb_valid), .word_ready(word_ready),
    .err_len(lsb_err_len), .overflow(lsb_overflow), .clr_err(clr_err)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  always @(negedge clk) begin
    if (err_len) err_cnt++;
    if (rnd_on && word_valid && word_ready) got_q.push_back(word_data);
    if (rnd_on && lsb_valid && word_ready) got_lsb_q.push_back(lsb_data);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send_bit(input logic b);
    ser_data = b;
    #122 ser_clk = 1'b1;
    #244 ser_clk = 1'b0;
    #122;
  endtask

  // Sends seq[n-1] first; returns 1 ns after the clk edge where ser_en fell.
  task automatic burst(input logic [39:0] seq, input int n);
    @(posedge clk); #1 ser_en = 1'b1;
    #200;
    for (int i = 0; i < n; i++) send_bit(seq[n-1-i]);
    #100;
    @(posedge clk); #1 ser_en = 1'b0;
  endtask

  typedef struct {
    logic [39:0] seq;
    int          n;
    bit          trail;
    bit          exp_word;
    logic [31:0] exp_data;
    bit          exp_err;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int          err0;
    logic [31:0] last_data;
    logic [39:0] seq;
    int          n;
    logic [31:0] wm;
    logic [31:0] wl;
    int          exp_err;

    rst_n = 1'b0; ser_en = 1'b0; ser_clk = 1'b0; ser_data = 1'b0;
    word_ready = 1'b1; clr_err = 1'b0;

    vecs[0] = '{40'hA5C30F81,   32, 1'b0, 1'b1, 32'hA5C30F81, 1'b0};
    vecs[1] = '{40'h2AAAAAAA,   31, 1'b1, 1'b0, 32'h0,        1'b1};
    vecs[2] = '{40'h123456789,  33, 1'b0, 1'b0, 32'h0,        1'b1};
    vecs[3] = '{40'hFFFF0000,   32, 1'b0, 1'b1, 32'hFFFF0000, 1'b0};
    vecs[4] = '{40'h0,          0,  1'b0, 1'b0, 32'h0,        1'b1};
    vecs[5] = '{40'h00000001,   32, 1'b0, 1'b1, 32'h00000001, 1'b0};

    #35;
    check("reset_data",     64'(word_data),  64'(0));
    check("reset_valid",    64'(word_valid), 64'(0));
    check("reset_err_len",  64'(err_len),    64'(0));
    check("reset_overflow", 64'(overflow),   64'(0));
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (5) @(posedge clk);

    // Table: ready held high, exact valid/err_len timing after ser_en falls.
    last_data = 32'h0;
    for (int k = 0; k < 6; k++) begin
      err0 = err_cnt;
      burst(vecs[k].seq, vecs[k].n);
      fork
        begin
          if (vecs[k].trail) begin
            #121 ser_clk = 1'b1;
            #244 ser_clk = 1'b0;
          end
        end
        begin
          repeat (4) @(posedge clk); @(negedge clk);
          check($sformatf("v%0d_valid_early", k), 64'(word_valid), 64'(0));
          @(posedge clk); @(negedge clk);
          if (vecs[k].exp_word) last_data = vecs[k].exp_data;
          check($sformatf("v%0d_valid", k), 64'(word_valid), 64'(vecs[k].exp_word));
          check($sformatf("v%0d_data", k), 64'(word_data), 64'(last_data));
          check($sformatf("v%0d_err_len", k), 64'(err_len), 64'(vecs[k].exp_err));
          @(posedge clk); @(negedge clk);
          check($sformatf("v%0d_valid_pulse", k), 64'(word_valid), 64'(0));
          check($sformatf("v%0d_err_pulse", k), 64'(err_len), 64'(0));
        end
      join
      repeat (30) @(posedge clk); @(negedge clk);
      check($sformatf("v%0d_err_count", k), 64'(err_cnt - err0), 64'(vecs[k].exp_err));
      check($sformatf("v%0d_no_extra_word", k), 64'(word_valid), 64'(0));
      check($sformatf("v%0d_overflow", k), 64'(overflow), 64'(0));
    end

    // Back-to-back good bursts with ready low: second word dropped.
    word_ready = 1'b0;
    burst(40'h12345678, 32);
    repeat (5) @(posedge clk); @(negedge clk);
    check("b2b_first_valid", 64'(word_valid), 64'(1));
    check("b2b_first_data",  64'(word_data),  64'(32'h12345678));
    burst(40'hDEADBEEF, 32);
    repeat (5) @(posedge clk); @(negedge clk);
    check("b2b_data_held", 64'(word_data),  64'(32'h12345678));
    check("b2b_valid",     64'(word_valid), 64'(1));
    check("b2b_overflow",  64'(overflow),   64'(1));

    // clr_err coinciding with a fresh overflow event keeps overflow set.
    burst(40'h0F0F0F0F, 32);
    repeat (4) @(posedge clk); #1 clr_err = 1'b1;
    @(posedge clk); #1 clr_err = 1'b0;
    @(negedge clk);
    check("clr_coincide_overflow", 64'(overflow),  64'(1));
    check("clr_coincide_data",     64'(word_data), 64'(32'h12345678));
    @(posedge clk); #1 clr_err = 1'b1;
    @(posedge clk); #1 clr_err = 1'b0;
    @(negedge clk);
    check("clr_err_overflow", 64'(overflow), 64'(0));

    // Ready asserted exactly in the CHECK cycle while valid is high.
    burst(40'h0BADF00D, 32);
    repeat (4) @(posedge clk); #1 word_ready = 1'b1;
    @(posedge clk); #1 word_ready = 1'b0;
    @(negedge clk);
    check("coincide_valid",    64'(word_valid), 64'(1));
    check("coincide_data",     64'(word_data),  64'(32'h0BADF00D));
    check("coincide_overflow", 64'(overflow),   64'(0));
    word_ready = 1'b1;
    repeat (3) @(posedge clk); @(negedge clk);
    check("drain_valid", 64'(word_valid), 64'(0));

    // Reset mid-burst, released while ser_en is still high.
    err0 = err_cnt;
    @(posedge clk); #1 ser_en = 1'b1;
    #200;
    for (int i = 0; i < 10; i++) send_bit(1'b1);
    rst_n = 1'b0;
    #50;
    check("midrst_data",  64'(word_data),  64'(0));
    check("midrst_valid", 64'(word_valid), 64'(0));
    #50 rst_n = 1'b1;
    for (int i = 0; i < 22; i++) send_bit(1'b1);
    #100;
    @(posedge clk); #1 ser_en = 1'b0;
    repeat (20) @(posedge clk); @(negedge clk);
    check("midrst_no_err",   64'(err_cnt - err0), 64'(0));
    check("midrst_no_word",  64'(word_valid),     64'(0));
    burst(40'h00000001, 32);
    repeat (5) @(posedge clk); @(negedge clk);
    check("postrst_valid", 64'(word_valid), 64'(1));
    check("postrst_data",  64'(word_data),  64'(32'h00000001));
    repeat (10) @(posedge clk);

    // Bit order: 1 followed by 31 zeros.
    burst(40'h80000000, 32);
    repeat (5) @(posedge clk); @(negedge clk);
    check("order_msb_data",  64'(word_data), 64'(32'h80000000));
    check("order_lsb_valid", 64'(lsb_valid), 64'(1));
    check("order_lsb_data",  64'(lsb_data),  64'(32'h00000001));
    repeat (10) @(posedge clk);

    // Randomized bursts against a transaction-level model.
    err0 = err_cnt;
    exp_err = 0;
    rnd_on = 1'b1;
    for (int t = 0; t < 16; t++) begin
      n = ($urandom_range(0, 3) == 0) ? (($urandom_range(0, 1) == 0) ? 31 : 33) : 32;
      seq = {$urandom(), $urandom()};
      wm = '0;
      wl = '0;
      for (int i = 0; i < n; i++) begin
        if (i < 32) begin
          wm = {wm[30:0], seq[n-1-i]};
          wl[i] = seq[n-1-i];
        end
      end
      if (n == 32) begin
        exp_q.push_back(wm);
        exp_lsb_q.push_back(wl);
      end else begin
        exp_err++;
      end
      burst(seq, n);
      repeat (20) @(posedge clk);
    end
    @(negedge clk);
    rnd_on = 1'b0;
    check("rnd_word_count", 64'(got_q.size()), 64'(exp_q.size()));
    check("rnd_lsb_count",  64'(got_lsb_q.size()), 64'(exp_lsb_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < got_q.size())
        check($sformatf("rnd_word%0d", i), 64'(got_q[i]), 64'(exp_q[i]));
      if (i < got_lsb_q.size())
        check($sformatf("rnd_lsb%0d", i), 64'(got_lsb_q[i]), 64'(exp_lsb_q[i]));
    end
    check("rnd_err_count", 64'(err_cnt - err0), 64'(exp_err));
    check("rnd_overflow",  64'(overflow), 64'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
